// File: rtl/brick_pkg.sv
// Shared types and helpers for the brick field scorer: FSM states and the
// ball-cell to brick-index mapping.
package brick_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        MISS    = 3'd2,
        CLEARED = 3'd3,
        OVER    = 3'd4
    } state_t;

    localparam int IDX_W = 16;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] row_off;
    } brick_loc_t;

    function automatic int hp_width(input int hits);
        return $clog2(hits + 1);
    endfunction

    // Maps a grid cell to a brick; valid is low outside the brick area.
    function automatic brick_loc_t brick_locate(input int row, input int col,
                                                input int top_row, input int rows,
                                                input int cols, input int brick_w);
        brick_loc_t loc;
        loc.valid   = (row >= top_row) && (row < top_row + rows) && (col < cols * brick_w);
        loc.row_off = IDX_W'(row - top_row);
        loc.idx     = IDX_W'((row - top_row) * cols + col / brick_w);
        return loc;
    endfunction

endpackage

// File: rtl/brick_field_mem.sv
// Per-brick hit-point array with bulk reload, single-brick decrement and
// look-ahead flags used by the scorer for scoring and last-brick detection.
module brick_field_mem
    import brick_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 8,
    parameter int HITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reload,
    input  logic                 dec_en,
    input  logic [IDX_W-1:0]     dec_idx,
    output logic [ROWS*COLS-1:0] bricks_alive,
    output logic                 sel_alive,
    output logic                 dec_to_zero,
    output logic                 any_alive_after_dec
);

    localparam int N    = ROWS * COLS;
    localparam int HP_W = hp_width(HITS);

    logic [HP_W-1:0] r_hp [N];
    logic [N-1:0]    w_sel;
    logic [N-1:0]    w_kill;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_sel[i]        = (dec_idx == IDX_W'(i));
            bricks_alive[i] = (r_hp[i] != '0);
            w_kill[i]       = dec_en && w_sel[i] && (r_hp[i] == HP_W'(1));
        end
    end

    assign sel_alive           = |(bricks_alive & w_sel);
    assign dec_to_zero         = |w_kill;
    assign any_alive_after_dec = |(bricks_alive & ~w_kill);

    // NOTE: the hp array is a small register file, not RAM, so it takes the
    // async reset like any other state; an empty field must be visible at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_hp[i] <= '0;
        end else if (reload) begin
            for (int i = 0; i < N; i++) r_hp[i] <= HP_W'(HITS);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (dec_en && w_sel[i] && r_hp[i] != '0)
                    r_hp[i] <= r_hp[i] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/brick_field_scorer.sv
// Game sequencer for a multi-hit brick field: collision resolution, row-weighted
// saturating score, lives, level counter and the registered hit pulse.
module brick_field_scorer
    import brick_pkg::*;
#(
    parameter int ROWS      = 7,
    parameter int COLS      = 8,
    parameter int BRICK_W   = 2,
    parameter int TOP_ROW   = 1,
    parameter int FLOOR_ROW = 11,
    parameter int HITS      = 2,
    parameter int LIVES     = 3,
    parameter int SCORE_W   = 10,
    parameter int POS_W     = 4,
    localparam int LIVES_W  = $clog2(LIVES + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ball_valid,
    input  logic [POS_W-1:0]     ball_row,
    input  logic [POS_W-1:0]     ball_col,
    output logic [ROWS*COLS-1:0] bricks_alive,
    output logic                 hit,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic [3:0]           level,
    output logic [2:0]           state,
    output logic                 game_over,
    output logic                 level_clear
);

    state_t               r_state, w_next_state;
    logic [SCORE_W-1:0]   r_score;
    logic [LIVES_W-1:0]   r_lives;
    logic [3:0]           r_level;
    logic                 r_hit;

    brick_loc_t           w_loc;
    logic                 w_sel_alive, w_dec_to_zero, w_any_after;
    logic                 w_floor, w_strike, w_new_game, w_new_level;
    logic [SCORE_W:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_sat;

    assign w_loc = brick_locate(int'(ball_row), int'(ball_col), TOP_ROW, ROWS, COLS, BRICK_W);

    // The floor is checked first so a floor row never doubles as a brick row.
    assign w_floor  = (r_state == PLAY) && ball_valid && (ball_row == POS_W'(FLOOR_ROW));
    assign w_strike = (r_state == PLAY) && ball_valid && !w_floor && w_loc.valid && w_sel_alive;

    assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(ROWS - int'(w_loc.row_off));
    assign w_score_sat = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

    brick_field_mem #(
        .ROWS (ROWS),
        .COLS (COLS),
        .HITS (HITS)
    ) u_mem (
        .clock               (clock),
        .reset               (reset),
        .reload              (w_new_game || w_new_level),
        .dec_en              (w_strike),
        .dec_idx             (w_loc.idx),
        .bricks_alive        (bricks_alive),
        .sel_alive           (w_sel_alive),
        .dec_to_zero         (w_dec_to_zero),
        .any_alive_after_dec (w_any_after)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_new_game   = 1'b0;
        w_new_level  = 1'b0;
        case (r_state)
            IDLE, OVER: begin
                if (start) begin
                    w_next_state = PLAY;
                    w_new_game   = 1'b1;
                end
            end
            CLEARED: begin
                if (start) begin
                    w_next_state = PLAY;
                    w_new_level  = 1'b1;
                end
            end
            PLAY: begin
                if (w_floor)
                    w_next_state = (r_lives > LIVES_W'(1)) ? MISS : OVER;
                else if (w_strike && !w_any_after)
                    w_next_state = CLEARED;
            end
            MISS: begin
                if (ball_valid && ball_row != POS_W'(FLOOR_ROW))
                    w_next_state = PLAY;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_score <= '0;
            r_lives <= LIVES_W'(LIVES);
            r_level <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_hit <= w_strike;
            if (w_new_game) begin
                r_score <= '0;
                r_lives <= LIVES_W'(LIVES);
                r_level <= '0;
            end else if (w_new_level) begin
                if (r_level != 4'd15) r_level <= r_level + 4'd1;
            end else begin
                if (w_floor)                   r_lives <= r_lives - LIVES_W'(1);
                if (w_strike && w_dec_to_zero) r_score <= w_score_sat;
            end
        end
    end

    assign hit         = r_hit;
    assign score       = r_score;
    assign lives       = r_lives;
    assign level       = r_level;
    assign state       = r_state;
    assign game_over   = (r_state == OVER);
    assign level_clear = (r_state == CLEARED);

endmodule
